clkdiv_multi: RTL

//  Parametrised multi-channel clock-enable/divider, successor to the fixed 25 MHz generator.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_channel.sv | 92 +++++++++
 rtl/clkdiv_multi.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock-enable divider.
// Holds the lock FSM encoding, the channel-count ceiling and the
// helper that sizes the channel-select port.
package clkdiv_pkg;

    localparam int CH_MAX = 16;

    typedef enum logic [0:0] {
        LK_SETTLE = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_t;

    // Width of the channel-select field; a single channel still gets one bit.
    function automatic int ch_sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/pending ratio registers,
// registered enable pulse and square wave, and the apply strobe that
// swaps in a pending ratio on a period boundary.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(4)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    input  logic             i_sync,
    output logic             o_pending,
    output logic             o_apply,
    output logic             o_ce,
    output logic             o_sq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pending;
    logic             r_ce;
    logic             r_sq;

    logic w_stopped;
    logic w_last;
    logic w_fall;
    logic w_apply;

    // A ratio of zero parks the channel; otherwise the last count is D-1.
    assign w_stopped = (r_div == '0);
    assign w_last    = !w_stopped && (r_cnt == (r_div - ONE));
    // Square wave drops after count floor(D/2)-1; D==1 never drives it high.
    assign w_fall    = (r_div > ONE) && (r_cnt == ((r_div >> 1) - ONE));
    // A pending ratio lands on the next period boundary, or at once when parked.
    assign w_apply   = r_pending && (w_stopped || w_last);

    // Ratio registers: accept into the pending slot, promote it on apply.
    // Accept and apply never coincide because accept requires !pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= DIV_RST;
            r_pend_div <= '0;
            r_pending  <= 1'b0;
        end else if (i_wr) begin
            r_pend_div <= i_wr_div;
            r_pending  <= 1'b1;
        end else if (w_apply) begin
            r_div      <= r_pend_div;
            r_pending  <= 1'b0;
        end
    end

    // Counter and outputs. The boundary pulse of the old period is always
    // emitted; the square wave only rises if the incoming ratio can toggle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end else if (w_apply) begin
            r_cnt <= '0;
            r_ce  <= w_last;
            r_sq  <= w_last && (r_pend_div > ONE);
        end else if (i_sync || w_stopped) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
            r_sq  <= 1'b0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_ce  <= 1'b1;
            r_sq  <= (r_div > ONE);
        end else begin
            r_cnt <= r_cnt + ONE;
            r_ce  <= 1'b0;
            if (w_fall) begin
                r_sq <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_apply   = w_apply;
    assign o_ce      = r_ce;
    assign o_sq      = r_sq;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock-enable / divider top.
// Decodes runtime ratio writes onto NUM_CH channels, reports readiness per
// addressed channel, and holds LOCKED low for LOCK_CYCLES after any ratio
// change. Optional feature macro: CLKDIV_PHASE_SYNC_EN adds the i_sync port
// that realigns every channel counter to a common phase.
//
// Lock FSM states
//   state     | meaning
//   LK_SETTLE | counting down settle cycles, o_locked low
//   LK_LOCKED | all channels stable, o_locked high
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int                        NUM_CH      = 2,
    parameter int                        CNT_W       = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT    = {NUM_CH{CNT_W'(4)}},
    parameter int                        LOCK_CYCLES = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_cfg_valid,
    output logic                              o_cfg_ready,
    input  logic [ch_sel_width(NUM_CH)-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]                  i_cfg_div,
    output logic [NUM_CH-1:0]                 o_ce_out,
    output logic [NUM_CH-1:0]                 o_sq_out,
    output logic                              o_locked
`ifdef CLKDIV_PHASE_SYNC_EN
    ,
    input  logic                              i_sync
`endif
);

    localparam int              CH_W      = ch_sel_width(NUM_CH);
    localparam int              LK_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_RELOAD = LK_W'(LOCK_CYCLES - 1);

    if (NUM_CH < 1 || NUM_CH > CH_MAX) begin : g_bad_num_ch
        $error("clkdiv_multi: NUM_CH must be 1..16");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
        $error("clkdiv_multi: LOCK_CYCLES must be at least 1");
    end

    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_apply;
    logic              w_ready;
    logic              w_sync;
    logic              w_restart;

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    logic [LK_W-1:0]   r_settle;
    logic [LK_W-1:0]   w_settle_nxt;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign w_sync = i_sync;
`else
    assign w_sync = 1'b0;
`endif

    // Ready follows the pending flag of the addressed channel; selects beyond
    // NUM_CH report ready and are simply ignored so a master cannot hang.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((i_cfg_ch == CH_W'(i)) && w_pending[i]) begin
                w_ready = 1'b0;
            end
        end
    end

    assign o_cfg_ready = w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = i_cfg_valid && w_ready && (i_cfg_ch == CH_W'(g));

        clkdiv_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_wr      (w_wr[g]),
            .i_wr_div  (i_cfg_div),
            .i_sync    (w_sync),
            .o_pending (w_pending[g]),
            .o_apply   (w_apply[g]),
            .o_ce      (o_ce_out[g]),
            .o_sq      (o_sq_out[g])
        );
    end

    assign w_restart = (|w_apply) || w_sync;

    // Lock FSM state and settle down-counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= LK_SETTLE;
            r_settle <= LK_RELOAD;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    // Lock FSM next state: any ratio change or realign restarts the settle count.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        if (w_restart) begin
            w_state_nxt  = LK_SETTLE;
            w_settle_nxt = LK_RELOAD;
        end else begin
            case (r_state)
                LK_SETTLE: begin
                    if (r_settle == '0) begin
                        w_state_nxt = LK_LOCKED;
                    end else begin
                        w_settle_nxt = r_settle - LK_W'(1);
                    end
                end
                LK_LOCKED: begin
                    w_state_nxt = LK_LOCKED;
                end
                default: begin
                    w_state_nxt  = LK_SETTLE;
                    w_settle_nxt = LK_RELOAD;
                end
            endcase
        end
    end

    assign o_locked = (r_state == LK_LOCKED);

endmodule
